// File: rtl/if_id_ctrl_pkg.sv
// rtl/if_id_ctrl_pkg.sv - shared state encoding and limits for the IF/ID controller
package if_id_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam int unsigned MAX_INSTR_LEN = 5;
  localparam int unsigned PERF_CNT_W    = 16;

  function automatic logic len_legal(input logic [2:0] len);
    return (len != 3'd0) && (len <= 3'(MAX_INSTR_LEN));
  endfunction

endpackage

// File: rtl/fe_pc_next.sv
// rtl/fe_pc_next.sv - next fetch address and instruction-length legality check
module fe_pc_next
  import if_id_ctrl_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  len,
  output logic [31:0] pc_next,
  output logic        len_ok
);

  // Illegal lengths still step by one byte so fetch never stalls on a bad length.
  always_comb begin
    len_ok  = len_legal(len);
    pc_next = pc + (len_ok ? {29'd0, len} : 32'd1);
  end

endmodule

// File: rtl/if_id_ctrl.sv
// rtl/if_id_ctrl.sv - IF/ID pipeline control: fetch PC, stall/flush, halt, redirect bubbles
// Optional stall/flush event counters are built when IF_ID_CTRL_PERF_EN is defined.
module if_id_ctrl
  import if_id_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [2:0]  fetch_len,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] fetch_pc,
  output logic        fetch_en,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        halted,
  output logic        len_err
`ifdef IF_ID_CTRL_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  bubble_q, bubble_d;
  logic        len_err_q, len_err_d;

  logic [31:0] pc_next;
  logic        len_ok;
  logic        accept;
  logic        redirect_take;

  fe_pc_next u_fe_pc_next (
    .pc      (fetch_pc_q),
    .len     (fetch_len),
    .pc_next (pc_next),
    .len_ok  (len_ok)
  );

  assign accept        = (state_q == ST_RUN) & fetch_valid & id_ready & ~redirect_valid;
  assign redirect_take = redirect_valid & ((state_q == ST_RUN) | (state_q == ST_FLUSH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    bubble_d   = bubble_q;
    len_err_d  = len_err_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN, ST_FLUSH: begin
        if (redirect_take) begin
          fetch_pc_d = redirect_pc;
          if (FLUSH_CYCLES == 0) begin
            state_d  = ST_RUN;
            bubble_d = 2'd0;
          end else begin
            state_d  = ST_FLUSH;
            bubble_d = FLUSH_INIT;
          end
        end else if (state_q == ST_RUN) begin
          if (accept) begin
            fetch_pc_d = pc_next;
            if (!len_ok) len_err_d = 1'b1;
          end
          if (halt_req) state_d = ST_HALT;
        end else begin
          // Leave FLUSH on the edge where the bubble count hits zero.
          if (bubble_q <= 2'd1) begin
            bubble_d = 2'd0;
            state_d  = ST_RUN;
          end else begin
            bubble_d = bubble_q - 2'd1;
          end
        end
      end
      ST_HALT: begin
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (!halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      bubble_q   <= 2'd0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      bubble_q   <= bubble_d;
      len_err_q  <= len_err_d;
    end
  end

  always_comb begin
    fetch_en    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b1;
    halted      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (!redirect_valid) begin
          fetch_en    = 1'b1;
          if_id_stall = ~id_ready;
          if_id_flush = 1'b0;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign fetch_pc = fetch_pc_q;
  assign len_err  = len_err_q;

`ifdef IF_ID_CTRL_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q == ST_RUN) && fetch_valid && !id_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (redirect_take && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// tb/tb_if_id_ctrl.sv - directed self-checking bench for if_id_ctrl (FLUSH_CYCLES=2)
module tb_if_id_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid;
  logic [2:0]  fetch_len;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] fetch_pc;
  logic        fetch_en;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        halted;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  if_id_ctrl #(
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_valid    (fetch_valid),
    .fetch_len      (fetch_len),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .fetch_pc       (fetch_pc),
    .fetch_en       (fetch_en),
    .if_id_stall    (if_id_stall),
    .if_id_flush    (if_id_flush),
    .halted         (halted),
    .len_err        (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    id_ready       = 1'b0;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_valid = 1'b1; fetch_len = 3'd3; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0;
    #1;
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want %h", fetch_pc, 32'h0); end
    checks++; if ({fetch_en, if_id_stall, if_id_flush, halted, len_err} !== 5'b00100) begin errors++; $display("FAIL rst_outs got %b want %b", {fetch_en, if_id_stall, if_id_flush, halted, len_err}, 5'b00100); end
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++; if ({fetch_en, if_id_flush} !== 2'b01) begin errors++; $display("FAIL idle_outs got %b want %b", {fetch_en, if_id_flush}, 2'b01); end
    tick();
    checks++; if ({fetch_en, if_id_stall, if_id_flush} !== 3'b100) begin errors++; $display("FAIL run_outs got %b want %b", {fetch_en, if_id_stall, if_id_flush}, 3'b100); end
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL run_pc0 got %h want %h", fetch_pc, 32'h0); end
    tick();
    checks++; if (fetch_pc !== 32'h3) begin errors++; $display("FAIL run_pc3 got %h want %h", fetch_pc, 32'h3); end
    tick();
    checks++; if (fetch_pc !== 32'h6) begin errors++; $display("FAIL run_pc6 got %h want %h", fetch_pc, 32'h6); end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({if_id_stall, if_id_flush, fetch_en} !== 3'b101) begin errors++; $display("FAIL stall_outs[%0d] got %b want %b", i, {if_id_stall, if_id_flush, fetch_en}, 3'b101); end
      checks++; if (fetch_pc !== 32'h6) begin errors++; $display("FAIL stall_pc[%0d] got %h want %h", i, fetch_pc, 32'h6); end
      tick();
    end
    id_ready = 1'b1;
    #1;
    checks++; if (if_id_stall !== 1'b0) begin errors++; $display("FAIL stall_release got %b want %b", if_id_stall, 1'b0); end
    tick();
    checks++; if (fetch_pc !== 32'h9) begin errors++; $display("FAIL stall_resume_pc got %h want %h", fetch_pc, 32'h9); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h1000; id_ready = 1'b0;
    #1;
    checks++; if ({fetch_en, if_id_stall, if_id_flush} !== 3'b001) begin errors++; $display("FAIL redir_cycle got %b want %b", {fetch_en, if_id_stall, if_id_flush}, 3'b001); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if ({fetch_en, if_id_stall, if_id_flush} !== 3'b001) begin errors++; $display("FAIL flush1 got %b want %b", {fetch_en, if_id_stall, if_id_flush}, 3'b001); end
    checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("FAIL flush_pc got %h want %h", fetch_pc, 32'h1000); end
    tick();
    checks++; if ({fetch_en, if_id_stall, if_id_flush} !== 3'b001) begin errors++; $display("FAIL flush2 got %b want %b", {fetch_en, if_id_stall, if_id_flush}, 3'b001); end
    tick();
    checks++; if ({fetch_en, if_id_flush} !== 2'b10) begin errors++; $display("FAIL flush_done got %b want %b", {fetch_en, if_id_flush}, 2'b10); end
    checks++; if (fetch_pc !== 32'h1000) begin errors++; $display("FAIL redir_pc got %h want %h", fetch_pc, 32'h1000); end
    id_ready = 1'b1; fetch_len = 3'd4;
    tick();
    checks++; if (fetch_pc !== 32'h1004) begin errors++; $display("FAIL redir_accept got %h want %h", fetch_pc, 32'h1004); end
  endtask

  task automatic test_wrap();
    go_to(32'hFFFF_FFFE);
    fetch_valid = 1'b1; id_ready = 1'b1; fetch_len = 3'd3;
    tick();
    checks++; if (fetch_pc !== 32'h0000_0001) begin errors++; $display("FAIL wrap_pc got %h want %h", fetch_pc, 32'h0000_0001); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL wrap_len_err got %b want %b", len_err, 1'b0); end
  endtask

  task automatic test_len();
    go_to(32'hFFFF_FFFF);
    id_ready = 1'b1; fetch_len = 3'd0;
    tick();
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL len0_pc got %h want %h", fetch_pc, 32'h0); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len0_err got %b want %b", len_err, 1'b1); end
    fetch_len = 3'd7;
    tick();
    checks++; if (fetch_pc !== 32'h1) begin errors++; $display("FAIL len7_pc got %h want %h", fetch_pc, 32'h1); end
    fetch_len = 3'd5;
    tick();
    checks++; if (fetch_pc !== 32'h6) begin errors++; $display("FAIL len5_pc got %h want %h", fetch_pc, 32'h6); end
    fetch_len = 3'd1;
    tick();
    checks++; if (fetch_pc !== 32'h7) begin errors++; $display("FAIL len1_pc got %h want %h", fetch_pc, 32'h7); end
    checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_err_sticky got %b want %b", len_err, 1'b1); end
  endtask

  task automatic test_halt();
    fetch_valid = 1'b1; id_ready = 1'b1; fetch_len = 3'd2;
    redirect_valid = 1'b1; redirect_pc = 32'h2000; halt_req = 1'b1;
    #1;
    checks++; if ({fetch_en, if_id_stall, if_id_flush, halted} !== 4'b0010) begin errors++; $display("FAIL halt_redir_cycle got %b want %b", {fetch_en, if_id_stall, if_id_flush, halted}, 4'b0010); end
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if ({if_id_flush, halted} !== 2'b10) begin errors++; $display("FAIL halt_flush1 got %b want %b", {if_id_flush, halted}, 2'b10); end
    tick();
    checks++; if ({if_id_flush, halted} !== 2'b10) begin errors++; $display("FAIL halt_flush2 got %b want %b", {if_id_flush, halted}, 2'b10); end
    tick();
    checks++; if ({fetch_en, halted} !== 2'b10) begin errors++; $display("FAIL halt_run got %b want %b", {fetch_en, halted}, 2'b10); end
    checks++; if (fetch_pc !== 32'h2000) begin errors++; $display("FAIL halt_run_pc got %h want %h", fetch_pc, 32'h2000); end
    tick();
    checks++; if ({fetch_en, if_id_stall, if_id_flush, halted} !== 4'b0011) begin errors++; $display("FAIL halt_state got %b want %b", {fetch_en, if_id_stall, if_id_flush, halted}, 4'b0011); end
    checks++; if (fetch_pc !== 32'h2002) begin errors++; $display("FAIL halt_entry_pc got %h want %h", fetch_pc, 32'h2002); end
    redirect_valid = 1'b1; redirect_pc = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_redir_stay got %b want %b", halted, 1'b1); end
    checks++; if (fetch_pc !== 32'h3000) begin errors++; $display("FAIL halt_redir_pc got %h want %h", fetch_pc, 32'h3000); end
    halt_req = 1'b0;
    tick();
    checks++; if ({fetch_en, halted} !== 2'b10) begin errors++; $display("FAIL halt_exit got %b want %b", {fetch_en, halted}, 2'b10); end
    checks++; if (fetch_pc !== 32'h3000) begin errors++; $display("FAIL halt_exit_pc got %h want %h", fetch_pc, 32'h3000); end
    tick();
    checks++; if (fetch_pc !== 32'h3002) begin errors++; $display("FAIL halt_resume_pc got %h want %h", fetch_pc, 32'h3002); end
  endtask

  task automatic test_reset_mid_flush();
    redirect_valid = 1'b1; redirect_pc = 32'h4000;
    tick();
    redirect_valid = 1'b0; fetch_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_pc got %h want %h", fetch_pc, 32'h0); end
    checks++; if ({fetch_en, if_id_stall, if_id_flush, halted, len_err} !== 5'b00100) begin errors++; $display("FAIL mid_rst_outs got %b want %b", {fetch_en, if_id_stall, if_id_flush, halted, len_err}, 5'b00100); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; fetch_valid = 1'b1; id_ready = 1'b1; fetch_len = 3'd2;
    #1;
    checks++; if ({fetch_en, if_id_flush} !== 2'b01) begin errors++; $display("FAIL mid_rst_idle got %b want %b", {fetch_en, if_id_flush}, 2'b01); end
    tick();
    checks++; if ({fetch_en, if_id_flush, fetch_pc} !== {2'b10, 32'h0}) begin errors++; $display("FAIL mid_rst_run got %h want %h", {fetch_en, if_id_flush, fetch_pc}, {2'b10, 32'h0}); end
    tick();
    checks++; if ({fetch_en, if_id_flush, fetch_pc} !== {2'b10, 32'h2}) begin errors++; $display("FAIL mid_rst_no_bubble got %h want %h", {fetch_en, if_id_flush, fetch_pc}, {2'b10, 32'h2}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_wrap();
    test_len();
    test_halt();
    test_reset_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
